ro_freq_meter: RTL and testbench
================================

# ro_freq_meter

Measurement sequencer for the ring-oscillator array in `user_project_wrapper`. It enables the oscillator array and selects one of the 16 oscillators through the mux select. It then counts rising edges of the muxed oscillator output over a programmable gate window of clock cycles and returns each count over a valid/ready result port. It can measure one oscillator or sweep all 16 in order.

## Interface
Parameters:
- `CNT_W`, 24: edge-counter and result width.
- `GATE_W`, 24: gate-length width.
- `SETTLE_CYCLES`, 16: cycles the oscillator is enabled before counting starts. Must be at least `SYNC_STAGES` + 1.
- `SYNC_STAGES`, 2: synchronizer flops on `ro_i`.

Ports:
- `wb_clk_i` in 1: the only clock.
- `wb_rst_i` in 1: reset, synchronous, active-low.
- `start_i` in 1: single-cycle pulse that starts a measurement. Accepted only in IDLE.
- `cfg_sweep_i` in 1: 1 = measure selects 0..15 in order; 0 = measure `cfg_sel_i` only.
- `cfg_sel_i` in 4: oscillator select for single mode.
- `cfg_gate_i` in `GATE_W`: gate length in clock cycles.
- `ro_i` in 1: muxed oscillator output (`io_out[0]` net), asynchronous to `wb_clk_i`.
- `ro_en_o` out 1: oscillator enable (`start`, `io_in[5]` net).
- `ro_sel_o` out 4: mux select (`io_in[9:6]` net).
- `res_valid_o` out 1, `res_ready_i` in 1: result handshake.
- `res_sel_o` out 4: select of the result currently presented.
- `res_count_o` out `CNT_W`: rising-edge count.
- `res_ovf_o` out 1: the counter saturated.
- `busy_o` out 1: high in any state except IDLE.
- `done_o` out 1: one-cycle pulse when the run completes.
- `err_o` out 1: one-cycle pulse when a start is rejected.

## Operation
- **States:** IDLE, SETTLE, GATE, HOLD.
- **IDLE:**
  - `start_i` with `cfg_gate_i != 0`: latch the configuration and enter SETTLE.
  - `ro_sel_o` is set to `cfg_sel_i` in single mode, or 0 in sweep mode.
  - `start_i` with `cfg_gate_i == 0`: pulse `err_o` and stay in IDLE.
- **SETTLE:**
  - `ro_en_o` = 1 and the counter is cleared.
  - Lasts exactly `SETTLE_CYCLES` cycles, then GATE.
- **GATE:**
  - `ro_en_o` = 1. Lasts exactly the latched gate-length number of cycles.
  - Each rising edge of synchronized `ro_i` (sync & ~prev) detected in a GATE cycle adds 1 to the counter.
  - The counter saturates at all-ones and sets the overflow flag; it does not wrap.
- **HOLD:**
  - `ro_en_o` = 0 and `res_valid_o` = 1.
  - `res_sel_o`, `res_count_o` and `res_ovf_o` are stable until the transfer (`res_valid_o` & `res_ready_i`).
- **On transfer:**
  - Sweep mode with select < 15: increment `ro_sel_o` and enter SETTLE.
  - Otherwise: enter IDLE and pulse `done_o` in the following cycle.
- **Select stability:** `ro_sel_o` changes only while `ro_en_o` = 0. The mux is never switched during a count.
- **Start while busy:** `start_i` is ignored, with no error pulse. Configuration inputs are ignored while busy.
- **Frequency limit:** correct counts require an `ro_i` frequency below `wb_clk_i`/2. Faster oscillators must be prescaled upstream. This block does not detect the violation.

## Timing
- **Reset:** at the first clock edge with `wb_rst_i` = 0, all outputs go to 0, the state goes to IDLE, and the counter and synchronizer are cleared. This applies mid-run as well: reset immediately drops `ro_en_o` and `res_valid_o`, and no `done_o` pulse is produced.
- **Start:** `start_i` at cycle T gives `busy_o` = 1, `ro_en_o` = 1 and a valid `ro_sel_o` at T+1.
- **Result latency:**
  - `res_valid_o` rises at T+1+`SETTLE_CYCLES`+G, where G is the gate length.
  - An `ro_i` edge is counted if it is detected in GATE; detection is `SYNC_STAGES` + 1 cycles after the raw edge.
- **Sweep handshake:** a transfer at cycle H gives `ro_en_o` = 1 with the new select at H+1.
- **Completion:** after a final transfer at cycle H, `done_o` = 1 and `busy_o` = 0 at H+1.
- **Backpressure:** `res_ready_i` may stay low indefinitely. HOLD waits with the oscillator off.

## Structure
- **Package `ro_meas_pkg`:**
  - state enum `ro_meas_state_e`
  - `NUM_RO` = 16
  - `RO_SEL_W` = 4
- **Sub-module `ro_edge_sync`:**
  - `SYNC_STAGES`-deep synchronizer plus a previous-value flop.
  - Outputs a single-cycle rising-edge strobe.
  - Reset with the same synchronous active-low reset.
- **Top level:** FSM, gate timer, saturating counter and the result register.

## Test plan
- **Single measurement:**
  - Stimulus: `ro_i` square wave with period 4 clocks, `cfg_gate_i` = 100, `cfg_sel_i` = 5, `res_ready_i` = 1.
  - Required: `ro_sel_o` = 5 and `res_count_o` = 25 (±1 for the phase at the gate boundary). `ro_en_o` is high for exactly 116 cycles, then `done_o` pulses.
- **Sweep with backpressure:**
  - Stimulus: sweep mode, `cfg_gate_i` = 20, `res_ready_i` held low for 10 cycles on each result.
  - Required: 16 results with `res_sel_o` = 0..15 in order. `ro_en_o` = 0 throughout every HOLD. The select never changes while `ro_en_o` = 1.
- **Saturation:**
  - Stimulus: `CNT_W` = 4, `ro_i` with period 2, `cfg_gate_i` = 100.
  - Required: `res_count_o` = 15 and `res_ovf_o` = 1.
- **Rejected and ignored starts:**
  - `cfg_gate_i` = 0 with `start_i`: `err_o` pulses once and `busy_o` stays 0.
  - `start_i` during GATE: no effect on the run and no `err_o`.
- **Reset mid-GATE:**
  - Stimulus: `wb_rst_i` = 0 for one cycle during GATE.
  - Required: at the next edge all outputs are 0 and the state is IDLE. A new start then produces a correct count.
- **Idle oscillator:**
  - Stimulus: `ro_i` held at 1, `cfg_gate_i` = 50.
  - Required: `res_count_o` = 0 and `res_ovf_o` = 0.

Source files
------------

// File: rtl/ro_meas_pkg.sv
// Shared constants and FSM state type for the ring-oscillator frequency meter.
package ro_meas_pkg;

   localparam int unsigned NUM_RO   = 16;
   localparam int unsigned RO_SEL_W = 4;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StGate,
      StHold
   } ro_meas_state_e;

endpackage

// File: rtl/ro_edge_sync.sv
// Multi-flop synchronizer for an asynchronous input plus a rising-edge strobe.
module ro_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Measurement sequencer: enables/selects a ring oscillator, counts its edges over a gate
// window and hands each count out over a valid/ready port, optionally sweeping all selects.
module ro_freq_meter
   import ro_meas_pkg::*;
#(
   parameter int unsigned CNT_W         = 24,
   parameter int unsigned GATE_W        = 24,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                start_i,
   input  logic                cfg_sweep_i,
   input  logic [RO_SEL_W-1:0] cfg_sel_i,
   input  logic [GATE_W-1:0]   cfg_gate_i,
   input  logic                ro_i,
   output logic                ro_en_o,
   output logic [RO_SEL_W-1:0] ro_sel_o,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [RO_SEL_W-1:0] res_sel_o,
   output logic [CNT_W-1:0]    res_count_o,
   output logic                res_ovf_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o
);

   localparam int unsigned SetW  = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned TMR_W = (GATE_W > SetW) ? GATE_W : SetW;

   localparam logic [TMR_W-1:0]    SettleLoad = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]    CntMax     = '1;
   localparam logic [RO_SEL_W-1:0] LastSel    = RO_SEL_W'(NUM_RO - 1);

   ro_meas_state_e      state_q, state_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [GATE_W-1:0]   gate_q, gate_d;
   logic                sweep_q, sweep_d;
   logic [RO_SEL_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic [RO_SEL_W-1:0] res_sel_q, res_sel_d;
   logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
   logic                res_ovf_q, res_ovf_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                ro_rise;

   ro_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_edge_sync (
      .clk_i (wb_clk_i),
      .rst_ni(wb_rst_i),
      .d_i   (ro_i),
      .rise_o(ro_rise)
   );

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      gate_d    = gate_q;
      sweep_d   = sweep_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      res_sel_d = res_sel_q;
      res_cnt_d = res_cnt_q;
      res_ovf_d = res_ovf_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (cfg_gate_i == '0) begin
                  err_d = 1'b1;
               end else begin
                  gate_d  = cfg_gate_i;
                  sweep_d = cfg_sweep_i;
                  sel_d   = cfg_sweep_i ? '0 : cfg_sel_i;
                  tmr_d   = SettleLoad;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = StSettle;
               end
            end
         end

         StSettle: begin
            cnt_d = '0;
            ovf_d = 1'b0;
            if (tmr_q == '0) begin
               tmr_d   = TMR_W'(gate_q) - TMR_W'(1);
               state_d = StGate;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end

         StGate: begin
            // Saturate rather than wrap; the flag marks that the count reached all-ones.
            if (ro_rise) begin
               if (cnt_q != CntMax) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (cnt_q >= CntMax - 1'b1) begin
                  ovf_d = 1'b1;
               end
            end
            if (tmr_q == '0) begin
               res_sel_d = sel_q;
               res_cnt_d = cnt_d;
               res_ovf_d = ovf_d;
               state_d   = StHold;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end

         StHold: begin
            if (res_ready_i) begin
               if (sweep_q && (sel_q != LastSel)) begin
                  sel_d   = sel_q + 1'b1;
                  tmr_d   = SettleLoad;
                  state_d = StSettle;
               end else begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q   <= StIdle;
         tmr_q     <= '0;
         gate_q    <= '0;
         sweep_q   <= 1'b0;
         sel_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         res_sel_q <= '0;
         res_cnt_q <= '0;
         res_ovf_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         gate_q    <= gate_d;
         sweep_q   <= sweep_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         res_sel_q <= res_sel_d;
         res_cnt_q <= res_cnt_d;
         res_ovf_q <= res_ovf_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign busy_o      = (state_q != StIdle);
   assign ro_en_o     = (state_q == StSettle) || (state_q == StGate);
   assign res_valid_o = (state_q == StHold);
   assign ro_sel_o    = sel_q;
   assign res_sel_o   = res_sel_q;
   assign res_count_o = res_cnt_q;
   assign res_ovf_o   = res_ovf_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed/randomized bench for ro_freq_meter with an edge-counting reference model.
module tb_ro_freq_meter;

   localparam int S    = 16;
   localparam int SY   = 2;
   localparam int MAXC = 8192;

   logic        clk;
   logic        wb_rst;
   logic        start;
   logic        cfg_sweep;
   logic [3:0]  cfg_sel;
   logic [23:0] cfg_gate;
   logic        ro;
   logic        res_ready;

   logic        ro_en, res_valid, res_ovf, busy, done, err;
   logic [3:0]  ro_sel, res_sel;
   logic [23:0] res_count;

   logic        s_ro_en, s_res_valid, s_res_ovf, s_busy, s_done, s_err;
   logic [3:0]  s_ro_sel, s_res_sel;
   logic [3:0]  s_res_count;

   int   cyc;
   int   checks;
   int   errors;
   int   ro_mode;
   int   ro_period;
   int   en_cycles;
   logic prev_en;
   logic [3:0] prev_sel;
   bit   ro_hist [0:MAXC-1];

   ro_freq_meter dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (wb_rst),
      .start_i    (start),
      .cfg_sweep_i(cfg_sweep),
      .cfg_sel_i  (cfg_sel),
      .cfg_gate_i (cfg_gate),
      .ro_i       (ro),
      .ro_en_o    (ro_en),
      .ro_sel_o   (ro_sel),
      .res_valid_o(res_valid),
      .res_ready_i(res_ready),
      .res_sel_o  (res_sel),
      .res_count_o(res_count),
      .res_ovf_o  (res_ovf),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err)
   );

   ro_freq_meter #(
      .CNT_W(4)
   ) dut_sat (
      .wb_clk_i   (clk),
      .wb_rst_i   (wb_rst),
      .start_i    (start),
      .cfg_sweep_i(cfg_sweep),
      .cfg_sel_i  (cfg_sel),
      .cfg_gate_i (cfg_gate),
      .ro_i       (ro),
      .ro_en_o    (s_ro_en),
      .ro_sel_o   (s_ro_sel),
      .res_valid_o(s_res_valid),
      .res_ready_i(res_ready),
      .res_sel_o  (s_res_sel),
      .res_count_o(s_res_count),
      .res_ovf_o  (s_res_ovf),
      .busy_o     (s_busy),
      .done_o     (s_done),
      .err_o      (s_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Per-cycle invariants: mux frozen while enabled, oscillator off while a result waits.
   task automatic monitor();
      if (ro_en && prev_en) check("sel_stable_while_en", ro_sel, prev_sel);
      if (res_valid) check("en_low_in_hold", ro_en, 0);
      if (ro_en) en_cycles++;
      prev_en  = ro_en;
      prev_sel = ro_sel;
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      monitor();
      case (ro_mode)
         0:       ro = ((cyc % ro_period) < (ro_period / 2)) ? 1'b1 : 1'b0;
         1:       ro = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
         default: ro = 1'b1;
      endcase
      if (cyc < MAXC) ro_hist[cyc] = ro;
   endtask

   // Rising edges whose detection (SY cycles after the sampled transition) lands in the gate
   // window of a measurement launched at cycle x with gate length g.
   function automatic int model_edges(input int x, input int g);
      int n;
      int w0;
      int w1;
      n  = 0;
      w0 = x + 1 + S;
      w1 = x + S + g;
      for (int c = w0 - SY; c <= w1 - SY; c++) begin
         if (c >= 1 && c < MAXC && ro_hist[c] && !ro_hist[c-1]) n++;
      end
      return n;
   endfunction

   task automatic do_start(input logic sw, input logic [3:0] sel, input int g, output int t);
      cfg_sweep = sw;
      cfg_sel   = sel;
      cfg_gate  = 24'(g);
      start     = 1'b1;
      t         = cyc;
      tick();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_en", ro_en, 1);
      check("start_sel", ro_sel, sw ? 4'd0 : sel);
   endtask

   task automatic wait_result(input int x, input int g, input logic [3:0] esel, input int hold,
                              output int h);
      int k;
      int n;
      k = 0;
      while (!res_valid && k < 400) begin
         tick();
         k++;
      end
      if (!res_valid) begin
         check("valid_timeout", 0, 1);
         h = cyc;
         return;
      end
      n = model_edges(x, g);
      check("valid_latency", cyc, x + 1 + S + g);
      check("res_sel", res_sel, esel);
      check("res_count", res_count, n);
      check("res_ovf", res_ovf, 0);
      check("sat_valid", s_res_valid, 1);
      check("sat_count", s_res_count, (n >= 15) ? 15 : n);
      check("sat_ovf", s_res_ovf, (n >= 15) ? 1 : 0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", res_valid, 1);
         check("hold_count", res_count, n);
         check("hold_sel", res_sel, esel);
      end
      res_ready = 1'b1;
      h         = cyc;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      int t;
      int h;
      int x;
      int g;
      logic [3:0] sel;

      cyc       = 0;
      checks    = 0;
      errors    = 0;
      ro_mode   = 0;
      ro_period = 4;
      en_cycles = 0;
      prev_en   = 1'b0;
      prev_sel  = 4'd0;
      wb_rst    = 1'b0;
      start     = 1'b0;
      cfg_sweep = 1'b0;
      cfg_sel   = 4'd0;
      cfg_gate  = 24'd0;
      ro        = 1'b0;
      res_ready = 1'b0;

      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_en", ro_en, 0);
      check("rst_valid", res_valid, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_sel", ro_sel, 0);
      check("rst_count", res_count, 0);
      check("rst_ovf", res_ovf, 0);
      wb_rst = 1'b1;
      tick();

      // Single measurement, period-4 oscillator.
      en_cycles = 0;
      do_start(1'b0, 4'd5, 100, t);
      wait_result(t, 100, 4'd5, 0, h);
      check("single_range", (res_count >= 24 && res_count <= 26) ? 1 : 0, 1);
      check("single_done", done, 1);
      check("single_busy", busy, 0);
      check("single_en_cycles", en_cycles, S + 100);
      tick();
      check("single_done_pulse", done, 0);

      // Rejected start.
      cfg_gate = 24'd0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("reject_err", err, 1);
      check("reject_busy", busy, 0);
      tick();
      check("reject_err_pulse", err, 0);
      check("reject_busy2", busy, 0);

      // Start and config changes during GATE must be ignored.
      ro_mode = 1;
      do_start(1'b0, 4'd9, 40, t);
      repeat (S + 4) tick();
      start    = 1'b1;
      cfg_gate = 24'd0;
      cfg_sel  = 4'd3;
      tick();
      start = 1'b0;
      check("busy_start_err", err, 0);
      check("busy_start_busy", busy, 1);
      check("busy_start_sel", ro_sel, 9);
      wait_result(t, 40, 4'd9, 2, h);
      check("busy_start_done", done, 1);

      // Sweep with backpressure; config inputs scrambled after the start.
      do_start(1'b1, 4'd7, 20, t);
      cfg_sweep = 1'b0;
      cfg_gate  = 24'd5;
      cfg_sel   = 4'd12;
      x = t;
      for (int i = 0; i < 16; i++) begin
         wait_result(x, 20, 4'(i), 10, h);
         if (i < 15) begin
            check("sweep_next_en", ro_en, 1);
            check("sweep_next_sel", ro_sel, i + 1);
            check("sweep_busy", busy, 1);
            check("sweep_no_done", done, 0);
         end else begin
            check("sweep_done", done, 1);
            check("sweep_idle", busy, 0);
         end
         x = h;
      end

      // Saturation on the 4-bit instance with a period-2 oscillator.
      ro_mode   = 0;
      ro_period = 2;
      do_start(1'b0, 4'd2, 100, t);
      wait_result(t, 100, 4'd2, 0, h);
      check("sat_done", done, 1);

      // Idle (stuck-high) oscillator.
      ro_mode = 2;
      repeat (4) tick();
      do_start(1'b0, 4'd1, 50, t);
      wait_result(t, 50, 4'd1, 0, h);
      check("idle_count", res_count, 0);

      // Reset during GATE, then a fresh measurement.
      ro_mode = 1;
      do_start(1'b0, 4'd4, 60, t);
      repeat (S + 8) tick();
      check("pre_rst_en", ro_en, 1);
      wb_rst = 1'b0;
      tick();
      wb_rst = 1'b1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_en", ro_en, 0);
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_sel", ro_sel, 0);
      check("mid_rst_res_sel", res_sel, 0);
      check("mid_rst_count", res_count, 0);
      check("mid_rst_ovf", res_ovf, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_err", err, 0);
      repeat (3) begin
         tick();
         check("post_rst_no_done", done, 0);
      end
      g   = $urandom_range(10, 60);
      sel = 4'($urandom_range(0, 15));
      do_start(1'b0, sel, g, t);
      wait_result(t, g, sel, 1, h);
      check("post_rst_done", done, 1);

      // Random single measurements, including the minimum gate length.
      for (int r = 0; r < 4; r++) begin
         g   = (r == 0) ? 1 : $urandom_range(2, 80);
         sel = 4'($urandom_range(0, 15));
         do_start(1'b0, sel, g, t);
         wait_result(t, g, sel, $urandom_range(0, 3), h);
         check("rand_done", done, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
